// File: rtl/fetch_unit.sv
// Instruction-fetch stage: sequential PC generation, pipelined imem requests, DEPTH-entry prefetch FIFO.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_discarded counters.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_discarded
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("fetch_unit: DEPTH must be a power of 2 and >= 2");
  end

  entry_t          fifo [DEPTH];
  entry_t          head;
  logic [XLEN-1:0] fetch_pc, rsp_pc;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, inflight, discard;
  logic            issue, push, pop;
  logic            unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  // A FIFO slot is reserved at issue time, so outstanding + buffered never exceeds DEPTH.
  assign imem_req  = rst_n && !redirect_valid &&
                     ((CW+1)'(count) + (CW+1)'(inflight) < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;
  assign issue     = imem_req && imem_gnt;
  assign push      = imem_rvalid && !redirect_valid && (discard == '0);
  assign pop       = instr_valid && instr_ready && !redirect_valid;

  assign head           = fifo[rd_ptr];
  assign instr_valid    = (count != '0);
  assign instr          = instr_valid ? head.instr : 32'h0000_0013;
  assign instr_pc       = instr_valid ? head.pc : '0;
  assign instr_pc_plus4 = instr_valid ? head.pc + XLEN'(4) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
    end else if (redirect_valid) begin
      // Every response still outstanding after this edge belongs to the old path.
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      rsp_pc   <= {redirect_pc[XLEN-1:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= inflight - CW'(imem_rvalid);
      discard  <= inflight - CW'(imem_rvalid);
    end else begin
      if (issue) fetch_pc <= fetch_pc + XLEN'(4);
      inflight <= inflight + CW'(issue) - CW'(imem_rvalid);
      if (imem_rvalid && (discard != '0)) discard <= discard - CW'(1);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        rsp_pc <= rsp_pc + XLEN'(4);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) fifo[wr_ptr] <= '{instr: imem_rdata, pc: rsp_pc};
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched   <= '0;
      perf_discarded <= '0;
    end else begin
      if (push) perf_fetched <= perf_fetched + 32'd1;
      if (imem_rvalid && !push) perf_discarded <= perf_discarded + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(imem_rvalid && (inflight == '0)));
  end

endmodule
